imem_responder: RTL

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder.sv | 113 +++++++++++
 1 files changed

// File: rtl/imem_responder.sv
// Instruction memory with a valid/ready program loader; the CPU is held in reset until a program is loaded.
// INSTRUCTION is a zero-latency read of PC, and FAULT latches any fetch of an unwritten or out-of-range word.
module imem_responder #(
    parameter int DEPTH = 64,
    parameter int IW    = 19
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [31:0]             PC,
    output logic [IW-1:0]           INSTRUCTION,
    output logic                    CPU_RESET,
    input  logic                    LD_START,
    input  logic                    LD_VALID,
    output logic                    LD_READY,
    input  logic [IW-1:0]           LD_DATA,
    input  logic                    LD_LAST,
    output logic                    LOAD_DONE,
    output logic [$clog2(DEPTH):0]  LOAD_COUNT,
    output logic                    FAULT
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [31:0]   DEPTH_32 = 32'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IW-1:0]     mem [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [CW-1:0]     count;
    logic              start;
    logic              beat;
    logic [AW-1:0]     pc_idx;
    logic [AW-1:0]     wr_idx;
    logic              pc_bad;

    assign pc_idx = PC[AW-1:0];
    assign wr_idx = count[AW-1:0];
    // The range test guards the truncated index, so a wrapped PC never reads a valid word.
    assign pc_bad = (PC >= DEPTH_32) || !valid[pc_idx];

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        beat      = 1'b0;
        LD_READY  = 1'b0;
        case (state)
            IDLE: begin
                if (LD_START) begin
                    start     = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                LD_READY = (count < DEPTH_C) && !RESET;
                if (LD_VALID && LD_READY) begin
                    beat = 1'b1;
                    if (LD_LAST || count == DEPTH_C - CW'(1)) state_nxt = RUN;
                end
            end
            RUN: begin
                if (LD_START) begin
                    start     = 1'b1;
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        INSTRUCTION = '0;
        if (state == RUN && !pc_bad) INSTRUCTION = mem[pc_idx];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            count     <= '0;
            valid     <= '0;
            LOAD_DONE <= 1'b0;
            FAULT     <= 1'b0;
            CPU_RESET <= 1'b1;
        end else begin
            LOAD_DONE <= (state == LOAD) && (state_nxt == RUN);
            CPU_RESET <= (state_nxt != RUN);
            if (start) begin
                count <= '0;
                valid <= '0;
                FAULT <= 1'b0;
            end else begin
                if (beat) begin
                    valid[wr_idx] <= 1'b1;
                    count         <= count + CW'(1);
                end
                if (state == RUN && pc_bad) FAULT <= 1'b1;
            end
        end
    end

    // Storage itself is never reset; the valid bits decide what is readable.
    always_ff @(posedge CLK) begin
        if (beat && !RESET) mem[wr_idx] <= LD_DATA;
    end

    assign LOAD_COUNT = count;
endmodule
